hp_controller: RTL

- Initiator/consumer on the far side of the per-frame damage scan handshake.
- Once per frame it issues the scan start pulse and waits for scan completion.
- On completion it applies accumulated damage and heal to player HP, manages invulnerability frames and game-over, and emits a one-cycle bullet-removal mask for collided bullets.

---
 rtl/hp_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/hp_controller.sv
// ---------------------------------------------------------------------------
// hp_controller
//   Once per video frame, requests a damage scan from the collision scanner.
//   When the scan finishes, the controller updates player HP from the reported
//   damage and heal. It also handles invulnerability frames and game-over, and
//   returns a one-cycle mask of bullets that should be removed.
//
// Ports
//   clk, rst_n       : clock (rising edge) and asynchronous active-low reset
//   frame_tick       : one-cycle pulse per frame; requests a scan when idle
//   reset_game       : synchronous restart request
//   is_complete      : scan-done pulse; damage/heal/index_collide valid with it
//   damage[7:0]      : accumulated damage from the scan
//   heal             : scan saw a heal bullet
//   index_collide[2:0]: active-low per-bullet collided mask
//   start            : one-cycle scan start pulse
//   hp[7:0]          : current player HP
//   hit              : one-cycle pulse when nonzero damage is applied
//   invuln           : high while invulnerability frames remain
//   bullet_kill[2:0] : one-cycle active-high mask of bullets to remove
//   game_over        : high while HP is 0
//   scan_error       : sticky flag, set when a scan timed out
// ---------------------------------------------------------------------------
module hp_controller #(
    parameter int unsigned MAX_HP        = 100,
    parameter int unsigned HEAL_AMOUNT   = 5,
    parameter int unsigned INVULN_FRAMES = 30,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       reset_game,
    input  logic       is_complete,
    input  logic [7:0] damage,
    input  logic       heal,
    input  logic [2:0] index_collide,
    output logic       start,
    output logic [7:0] hp,
    output logic       hit,
    output logic       invuln,
    output logic [2:0] bullet_kill,
    output logic       game_over,
    output logic       scan_error
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned IW = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);

    localparam logic [7:0]    HP_MAX     = 8'(MAX_HP);
    localparam logic [8:0]    HP_MAX_9   = 9'(MAX_HP);
    localparam logic [8:0]    HEAL_9     = 9'(HEAL_AMOUNT);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT);
    localparam logic [IW-1:0] INV_RELOAD = IW'(INVULN_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_APPLY,
        ST_DEAD
    } state_t;

    // HP minus damage, floored at zero.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (b >= a) ? 8'd0 : (a - b);
    endfunction

    // Add the heal amount with a 9-bit sum so it cannot wrap, then clamp to MAX_HP.
    function automatic logic [7:0] heal_clamp(input logic [7:0] a, input logic add_heal);
        logic [8:0] sum;
        sum = {1'b0, a} + (add_heal ? HEAL_9 : 9'd0);
        return (sum > HP_MAX_9) ? HP_MAX : sum[7:0];
    endfunction

    state_t        state_q,       state_d;
    logic [7:0]    hp_q,          hp_d;
    logic          start_q,       start_d;
    logic          hit_q,         hit_d;
    logic          invuln_q,      invuln_d;
    logic [2:0]    bullet_kill_q, bullet_kill_d;
    logic          game_over_q,   game_over_d;
    logic          scan_error_q,  scan_error_d;
    logic [IW-1:0] invuln_cnt_q,  invuln_cnt_d;
    logic [TW-1:0] tmo_cnt_q,     tmo_cnt_d;
    logic [7:0]    dmg_cap_q,     dmg_cap_d;
    logic          heal_cap_q,    heal_cap_d;
    logic [2:0]    coll_cap_q,    coll_cap_d;

    logic [7:0] dmg_eff;
    logic [7:0] hp_sub;

    // Damage is ignored while invulnerable; the counter value seen here is the
    // value before any reload or decrement that happens in the same cycle.
    assign dmg_eff = (invuln_cnt_q != '0) ? 8'd0 : dmg_cap_q;
    assign hp_sub  = sat_sub(hp_q, dmg_eff);

    always_comb begin
        state_d       = state_q;
        hp_d          = hp_q;
        start_d       = 1'b0;
        hit_d         = 1'b0;
        bullet_kill_d = 3'b000;
        game_over_d   = game_over_q;
        scan_error_d  = scan_error_q;
        invuln_cnt_d  = invuln_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        dmg_cap_d     = dmg_cap_q;
        heal_cap_d    = heal_cap_q;
        coll_cap_d    = coll_cap_q;

        // Invulnerability runs in frames, not clock cycles. It is frozen once the player is dead.
        if (state_q != ST_DEAD && frame_tick && invuln_cnt_q != '0) begin
            invuln_cnt_d = invuln_cnt_q - IW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_REQ;
                    start_d = 1'b1;
                end
            end
            ST_REQ: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                // A completion in the same cycle as the timeout still counts.
                if (is_complete) begin
                    dmg_cap_d  = damage;
                    heal_cap_d = heal;
                    coll_cap_d = index_collide;
                    state_d    = ST_APPLY;
                end else if (tmo_cnt_d == TMO_LIMIT) begin
                    scan_error_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_APPLY: begin
                bullet_kill_d = ~coll_cap_q;
                if (dmg_eff != 8'd0) begin
                    hit_d        = 1'b1;
                    invuln_cnt_d = INV_RELOAD;
                end
                if (hp_sub == 8'd0) begin
                    hp_d        = 8'd0;
                    game_over_d = 1'b1;
                    state_d     = ST_DEAD;
                end else begin
                    hp_d    = heal_clamp(hp_sub, heal_cap_q);
                    state_d = ST_IDLE;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restart overrides everything else arriving in the same cycle.
        if (reset_game) begin
            state_d       = ST_IDLE;
            hp_d          = HP_MAX;
            start_d       = 1'b0;
            hit_d         = 1'b0;
            bullet_kill_d = 3'b000;
            game_over_d   = 1'b0;
            scan_error_d  = 1'b0;
            invuln_cnt_d  = '0;
            tmo_cnt_d     = '0;
        end

        invuln_d = (invuln_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hp_q          <= HP_MAX;
            start_q       <= 1'b0;
            hit_q         <= 1'b0;
            invuln_q      <= 1'b0;
            bullet_kill_q <= 3'b000;
            game_over_q   <= 1'b0;
            scan_error_q  <= 1'b0;
            invuln_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            dmg_cap_q     <= 8'd0;
            heal_cap_q    <= 1'b0;
            coll_cap_q    <= 3'b111;
        end else begin
            state_q       <= state_d;
            hp_q          <= hp_d;
            start_q       <= start_d;
            hit_q         <= hit_d;
            invuln_q      <= invuln_d;
            bullet_kill_q <= bullet_kill_d;
            game_over_q   <= game_over_d;
            scan_error_q  <= scan_error_d;
            invuln_cnt_q  <= invuln_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            dmg_cap_q     <= dmg_cap_d;
            heal_cap_q    <= heal_cap_d;
            coll_cap_q    <= coll_cap_d;
        end
    end

    assign start       = start_q;
    assign hp          = hp_q;
    assign hit         = hit_q;
    assign invuln      = invuln_q;
    assign bullet_kill = bullet_kill_q;
    assign game_over   = game_over_q;
    assign scan_error  = scan_error_q;

endmodule
